uart_rx: RTL

//  Serial receiver directly downstream of uart_tx: samples the line once per CLK (no baud divider).

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_if.sv | 37 +++
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_rx.sv | 123 ++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default data width and frame length.
// Used by both the receiver (uart_rx) and the transmitter (uart_tx).
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned UART_FRAME_LEN = UART_DATA_BITS + 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DATA    = 2'd1,
        STOP    = 2'd2,
        RECOVER = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, byte holding register out behind valid/ready, status pulses.
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = UART_DATA_BITS
) ();

    logic                 rx;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    // master: the receiver; slave: the line driver and byte consumer
    modport master (
        input  rx,
        input  ready,
        output data,
        output valid,
        output frame_err,
        output overrun,
        output busy
    );

    modport slave (
        output rx,
        output ready,
        input  data,
        input  valid,
        input  frame_err,
        input  overrun,
        input  busy
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line; both flops reset to the idle (high) level.
// Only compiled when UART_RX_SYNC_EN is defined, matching its single instantiation in uart_rx.
`ifdef UART_RX_SYNC_EN
module uart_rx_sync (
    input  logic CLK,
    input  logic RESETN,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule
`endif

// File: rtl/uart_rx.sv
// UART receiver sampling the line once per CLK, MSB-first frames, one-entry holding register.
// Optional: define UART_RX_SYNC_EN to insert a 2-flop synchronizer on rx (adds 2 cycles latency).
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = UART_DATA_BITS
) (
    input  logic      CLK,
    input  logic      RESETN,
    uart_rx_if.master bus
);

    localparam int unsigned CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    logic rx_s;

`ifdef UART_RX_SYNC_EN
    uart_rx_sync u_sync (
        .CLK    (CLK),
        .RESETN (RESETN),
        .d      (bus.rx),
        .q      (rx_s)
    );
`else
    assign rx_s = bus.rx;
`endif

    uart_state_t          state_q,     state_n;
    logic [CNT_W-1:0]     cnt_q,       cnt_n;
    logic [DATA_BITS-1:0] shift_q,     shift_n;
    logic [DATA_BITS-1:0] data_q,      data_n;
    logic                 valid_q,     valid_n;
    logic                 frame_err_q, frame_err_n;
    logic                 overrun_q,   overrun_n;
    logic                 busy_q,      busy_n;

    // State and output registers
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            shift_q     <= shift_n;
            data_q      <= data_n;
            valid_q     <= valid_n;
            frame_err_q <= frame_err_n;
            overrun_q   <= overrun_n;
            busy_q      <= busy_n;
        end
    end

    // Next-state, holding register and pulse logic
    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        shift_n     = shift_q;
        data_n      = data_q;
        valid_n     = valid_q;
        frame_err_n = 1'b0;
        overrun_n   = 1'b0;

        if (valid_q && bus.ready) begin
            valid_n = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_n = DATA;
                    cnt_n   = CNT_W'(DATA_BITS - 1);
                end
            end
            DATA: begin
                shift_n = {shift_q[DATA_BITS-2:0], rx_s};
                if (cnt_q == '0) begin
                    state_n = STOP;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            STOP: begin
                if (rx_s) begin
                    state_n = IDLE;
                    // A same-edge accept frees the register, so the new byte refills it
                    if (!valid_q || bus.ready) begin
                        data_n  = shift_q;
                        valid_n = 1'b1;
                    end else begin
                        overrun_n = 1'b1;
                    end
                end else begin
                    state_n     = RECOVER;
                    frame_err_n = 1'b1;
                end
            end
            RECOVER: begin
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = busy_q;

endmodule
